axi_mux: RTL and testbench

Merges `INPUT_NUM` AXI slave ports onto one AXI master port. It sits directly downstream of the ID-routing demux stages: the demux outputs from several sources that target the same destination converge here. AW and AR are arbitrated round-robin. A write grant is held until the WLAST beat completes. B and R responses are steered back to the originating input by ID range.

---
 rtl/axi_pkg.sv | 70 +++++++
 rtl/rr_arbiter.sv | 28 ++
 rtl/axi_mux.sv | 191 +++++++++++++++++++
 tb/tb_axi_mux.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_pkg.sv
// Shared AXI types, FSM encodings and the ID-range decode used by the mux and demux stages.
package axi_pkg;

  localparam int unsigned AXI_DW     = 32;
  localparam int unsigned AXI_IDW_W  = 4;
  localparam int unsigned AXI_IDR_W  = 4;
  localparam int unsigned AXI_AW     = 16;
  localparam int unsigned MAX_INPUTS = 8;

  typedef struct packed {
    logic [AXI_IDW_W-1:0] awid;
    logic [AXI_AW-1:0]    awaddr;
    logic [7:0]           awlen;
    logic [2:0]           awsize;
    logic [1:0]           awburst;
    logic                 awvalid;
    logic [AXI_DW-1:0]    wdata;
    logic [AXI_DW/8-1:0]  wstrb;
    logic                 wlast;
    logic                 wvalid;
    logic                 bready;
    logic [AXI_IDR_W-1:0] arid;
    logic [AXI_AW-1:0]    araddr;
    logic [7:0]           arlen;
    logic [2:0]           arsize;
    logic [1:0]           arburst;
    logic                 arvalid;
    logic                 rready;
  } axi_mosi_t;

  typedef struct packed {
    logic                 awready;
    logic                 wready;
    logic [AXI_IDW_W-1:0] bid;
    logic [1:0]           bresp;
    logic                 bvalid;
    logic                 arready;
    logic [AXI_IDR_W-1:0] rid;
    logic [AXI_DW-1:0]    rdata;
    logic [1:0]           rresp;
    logic                 rlast;
    logic                 rvalid;
  } axi_miso_t;

  localparam logic [1:0] W_ARB  = 2'd0;
  localparam logic [1:0] W_ADDR = 2'd1;
  localparam logic [1:0] W_DATA = 2'd2;

  localparam logic [0:0] R_ARB  = 1'b0;
  localparam logic [0:0] R_ADDR = 1'b1;

  // Routing table padded to the largest supported port count; unused pairs are ignored.
  typedef int unsigned routing_t [2*(MAX_INPUTS-1)];

  function automatic int unsigned id_to_port(input int unsigned id, input routing_t routing,
                                             input int unsigned n_in);
    int unsigned port;
    logic        found;
    port  = n_in - 1;
    found = 1'b0;
    for (int unsigned k = 0; k < MAX_INPUTS - 1; k++) begin
      if (!found && (k + 1 < n_in) && id >= routing[2*k] && id <= routing[2*k+1]) begin
        port  = k;
        found = 1'b1;
      end
    end
    return port;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping.
module rr_arbiter #(
  parameter int unsigned N = 3,
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] gnt_idx,
  output logic          gnt_valid
);

  logic [IW-1:0] idx;

  // Scan from the farthest offset down so the closest requester wins last.
  always_comb begin
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    idx       = '0;
    for (int unsigned k = N; k > 0; k--) begin
      idx = IW'((32'(ptr) + k - 1) % N);
      if (req[idx]) begin
        gnt_idx   = idx;
        gnt_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/axi_mux.sv
// N:1 AXI merge: round-robin AW/AR arbitration, write grant held to WLAST, B/R routed back by ID range.
module axi_mux
  import axi_pkg::*;
#(
  parameter int unsigned INPUT_NUM                    = 3,
  parameter int unsigned ID_ROUTING [(INPUT_NUM-1)*2] = '{0, 0, 1, 1},
  parameter int unsigned AXI_DATA_WIDTH               = 32,
  parameter int unsigned ID_W_WIDTH                   = 4,
  parameter int unsigned ID_R_WIDTH                   = 4,
  parameter int unsigned ADDR_WIDTH                   = 16
) (
  input  logic      ACLK,
  input  logic      ARESET,
  input  axi_mosi_t s_axi_i [INPUT_NUM],
  output axi_miso_t s_axi_o [INPUT_NUM],
  output axi_mosi_t m_axi_o,
  input  axi_miso_t m_axi_i
);

  localparam int unsigned SEL_W = $clog2(INPUT_NUM);

  if (INPUT_NUM < 2 || INPUT_NUM > MAX_INPUTS || AXI_DATA_WIDTH != AXI_DW ||
      ID_W_WIDTH != AXI_IDW_W || ID_R_WIDTH != AXI_IDR_W || ADDR_WIDTH != AXI_AW) begin : g_bad_cfg
    $error("axi_mux: parameters do not match the shared AXI struct layout");
  end

  routing_t route;
  for (genvar g = 0; g < 2*(MAX_INPUTS-1); g++) begin : g_route
    if (g < (INPUT_NUM-1)*2) begin : g_used
      assign route[g] = ID_ROUTING[g];
    end else begin : g_pad
      assign route[g] = 0;
    end
  end

  logic [1:0]       w_state_q, w_state_d;
  logic [0:0]       r_state_q, r_state_d;
  logic [SEL_W-1:0] wsel_q, wsel_d, w_ptr_q, w_ptr_d;
  logic [SEL_W-1:0] rsel_q, rsel_d, r_ptr_q, r_ptr_d;

  logic [INPUT_NUM-1:0] aw_req, ar_req;
  logic [SEL_W-1:0]     aw_gnt, ar_gnt;
  logic                 aw_gnt_valid, ar_gnt_valid;

  always_comb begin
    for (int unsigned i = 0; i < INPUT_NUM; i++) begin
      aw_req[i] = s_axi_i[i].awvalid;
      ar_req[i] = s_axi_i[i].arvalid;
    end
  end

  rr_arbiter #(.N(INPUT_NUM)) u_aw_arb (
    .req(aw_req), .ptr(w_ptr_q), .gnt_idx(aw_gnt), .gnt_valid(aw_gnt_valid)
  );

  rr_arbiter #(.N(INPUT_NUM)) u_ar_arb (
    .req(ar_req), .ptr(r_ptr_q), .gnt_idx(ar_gnt), .gnt_valid(ar_gnt_valid)
  );

  logic w_addr, w_active, aw_hs, wlast_hs, r_addr, ar_hs;
  logic [SEL_W-1:0] bsel, rrsel;

  assign w_addr   = (w_state_q == W_ADDR);
  assign w_active = w_addr || (w_state_q == W_DATA);
  assign aw_hs    = w_addr && s_axi_i[wsel_q].awvalid && m_axi_i.awready;
  assign wlast_hs = w_active && s_axi_i[wsel_q].wvalid && m_axi_i.wready && s_axi_i[wsel_q].wlast;
  assign r_addr   = (r_state_q == R_ADDR);
  assign ar_hs    = r_addr && s_axi_i[rsel_q].arvalid && m_axi_i.arready;

  assign bsel  = SEL_W'(id_to_port(32'(m_axi_i.bid), route, INPUT_NUM));
  assign rrsel = SEL_W'(id_to_port(32'(m_axi_i.rid), route, INPUT_NUM));

  always_comb begin
    w_state_d = w_state_q;
    wsel_d    = wsel_q;
    w_ptr_d   = w_ptr_q;
    unique case (w_state_q)
      W_ARB: begin
        if (aw_gnt_valid) begin
          wsel_d    = aw_gnt;
          w_state_d = W_ADDR;
        end
      end
      W_ADDR: begin
        if (aw_hs) begin
          w_ptr_d   = (wsel_q == SEL_W'(INPUT_NUM-1)) ? '0 : wsel_q + 1'b1;
          w_state_d = wlast_hs ? W_ARB : W_DATA;
        end
      end
      W_DATA: begin
        if (wlast_hs) w_state_d = W_ARB;
      end
      default: w_state_d = W_ARB;
    endcase
  end

  always_comb begin
    r_state_d = r_state_q;
    rsel_d    = rsel_q;
    r_ptr_d   = r_ptr_q;
    unique case (r_state_q)
      R_ARB: begin
        if (ar_gnt_valid) begin
          rsel_d    = ar_gnt;
          r_state_d = R_ADDR;
        end
      end
      R_ADDR: begin
        if (ar_hs) begin
          r_ptr_d   = (rsel_q == SEL_W'(INPUT_NUM-1)) ? '0 : rsel_q + 1'b1;
          r_state_d = R_ARB;
        end
      end
      default: r_state_d = R_ARB;
    endcase
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      w_state_q <= W_ARB;
      r_state_q <= R_ARB;
      wsel_q    <= '0;
      w_ptr_q   <= '0;
      rsel_q    <= '0;
      r_ptr_q   <= '0;
    end else begin
      w_state_q <= w_state_d;
      r_state_q <= r_state_d;
      wsel_q    <= wsel_d;
      w_ptr_q   <= w_ptr_d;
      rsel_q    <= rsel_d;
      r_ptr_q   <= r_ptr_d;
    end
  end

  // Response steering is combinational, so it is gated while reset is held.
  always_comb begin
    m_axi_o = '0;
    for (int unsigned i = 0; i < INPUT_NUM; i++) s_axi_o[i] = '0;

    if (w_addr) begin
      m_axi_o.awid    = s_axi_i[wsel_q].awid;
      m_axi_o.awaddr  = s_axi_i[wsel_q].awaddr;
      m_axi_o.awlen   = s_axi_i[wsel_q].awlen;
      m_axi_o.awsize  = s_axi_i[wsel_q].awsize;
      m_axi_o.awburst = s_axi_i[wsel_q].awburst;
      m_axi_o.awvalid = s_axi_i[wsel_q].awvalid;
    end
    if (w_active) begin
      m_axi_o.wdata  = s_axi_i[wsel_q].wdata;
      m_axi_o.wstrb  = s_axi_i[wsel_q].wstrb;
      m_axi_o.wlast  = s_axi_i[wsel_q].wlast;
      m_axi_o.wvalid = s_axi_i[wsel_q].wvalid;
    end
    if (r_addr) begin
      m_axi_o.arid    = s_axi_i[rsel_q].arid;
      m_axi_o.araddr  = s_axi_i[rsel_q].araddr;
      m_axi_o.arlen   = s_axi_i[rsel_q].arlen;
      m_axi_o.arsize  = s_axi_i[rsel_q].arsize;
      m_axi_o.arburst = s_axi_i[rsel_q].arburst;
      m_axi_o.arvalid = s_axi_i[rsel_q].arvalid;
    end
    if (!ARESET) begin
      m_axi_o.bready = s_axi_i[bsel].bready;
      m_axi_o.rready = s_axi_i[rrsel].rready;
    end

    for (int unsigned i = 0; i < INPUT_NUM; i++) begin
      if (SEL_W'(i) == wsel_q) begin
        s_axi_o[i].awready = w_addr && m_axi_i.awready;
        s_axi_o[i].wready  = w_active && m_axi_i.wready;
      end
      if (SEL_W'(i) == rsel_q) begin
        s_axi_o[i].arready = r_addr && m_axi_i.arready;
      end
      if (!ARESET && SEL_W'(i) == bsel) begin
        s_axi_o[i].bvalid = m_axi_i.bvalid;
        s_axi_o[i].bid    = m_axi_i.bid;
        s_axi_o[i].bresp  = m_axi_i.bresp;
      end
      if (!ARESET && SEL_W'(i) == rrsel) begin
        s_axi_o[i].rvalid = m_axi_i.rvalid;
        s_axi_o[i].rid    = m_axi_i.rid;
        s_axi_o[i].rdata  = m_axi_i.rdata;
        s_axi_o[i].rresp  = m_axi_i.rresp;
        s_axi_o[i].rlast  = m_axi_i.rlast;
      end
    end
  end

endmodule

// File: tb/tb_axi_mux.sv
// Directed bench for axi_mux with a transaction-level ownership model checked every cycle.
module tb_axi_mux;
  import axi_pkg::*;

  localparam int N = 3;
  localparam int unsigned ROUTE [4] = '{0, 0, 1, 1};

  logic      ACLK = 1'b0;
  logic      ARESET = 1'b1;
  axi_mosi_t s_axi_i [N];
  axi_miso_t s_axi_o [N];
  axi_mosi_t m_axi_o;
  axi_miso_t m_axi_i;

  int checks = 0;
  int failures = 0;

  bit aw_req [N];
  int aw_len [N];
  int w_left [N];
  bit w_en [N];
  int w_beat [N];
  int ar_left [N];
  bit bready_v [N];
  bit rready_v [N];

  int aw_src[$], aw_cyc[$], w_src[$], w_cyc[$], ar_src[$], ar_cyc[$];
  int cyc = 0;

  bit wb, wad, rb;
  int wo, wp, ro, rp;

  axi_mux #(
    .INPUT_NUM(3), .ID_ROUTING(ROUTE), .AXI_DATA_WIDTH(32),
    .ID_W_WIDTH(4), .ID_R_WIDTH(4), .ADDR_WIDTH(16)
  ) dut (
    .ACLK(ACLK), .ARESET(ARESET), .s_axi_i(s_axi_i), .s_axi_o(s_axi_o),
    .m_axi_o(m_axi_o), .m_axi_i(m_axi_i)
  );

  always #5 ACLK = ~ACLK;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic int route_of(input int id);
    for (int k = 0; k < N - 1; k++)
      if (id >= int'(ROUTE[2*k]) && id <= int'(ROUTE[2*k+1])) return k;
    return N - 1;
  endfunction

  function automatic int first_req(input int p, input bit is_aw);
    int i;
    for (int k = 0; k < N; k++) begin
      i = (p + k) % N;
      if (is_aw ? s_axi_i[i].awvalid : s_axi_i[i].arvalid) return i;
    end
    return -1;
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge ACLK);
      #1;
    end
  endtask

  task automatic clear_up();
    for (int i = 0; i < N; i++) begin
      aw_req[i] = 0; aw_len[i] = 0; w_left[i] = 0; w_en[i] = 0; ar_left[i] = 0;
    end
  endtask

  // Upstream masters: consume handshakes seen before the edge, re-drive after it.
  initial begin
    for (int i = 0; i < N; i++) s_axi_i[i] = '0;
    forever begin
      @(negedge ACLK);
      for (int i = 0; i < N; i++) begin
        if (s_axi_i[i].awvalid && s_axi_o[i].awready) aw_req[i] = 0;
        if (s_axi_i[i].wvalid && s_axi_o[i].wready) begin
          w_left[i]--;
          w_beat[i]++;
        end
        if (s_axi_i[i].arvalid && s_axi_o[i].arready) ar_left[i]--;
      end
      @(posedge ACLK);
      #2;
      for (int i = 0; i < N; i++) begin
        s_axi_i[i]         = '0;
        s_axi_i[i].awid    = 4'(i);
        s_axi_i[i].awaddr  = 16'(i << 8) | 16'h0040;
        s_axi_i[i].awlen   = 8'(aw_len[i]);
        s_axi_i[i].awsize  = 3'd2;
        s_axi_i[i].awburst = 2'd1;
        s_axi_i[i].awvalid = aw_req[i];
        s_axi_i[i].wdata   = {4'(i), 20'h0, 8'(w_beat[i])};
        s_axi_i[i].wstrb   = '1;
        s_axi_i[i].wlast   = (w_left[i] == 1);
        s_axi_i[i].wvalid  = w_en[i] && (w_left[i] > 0);
        s_axi_i[i].bready  = bready_v[i];
        s_axi_i[i].arid    = 4'(i + 4);
        s_axi_i[i].araddr  = 16'(i << 8) | 16'h0080;
        s_axi_i[i].arsize  = 3'd2;
        s_axi_i[i].arburst = 2'd1;
        s_axi_i[i].arvalid = (ar_left[i] > 0);
        s_axi_i[i].rready  = rready_v[i];
      end
    end
  end

  // Model: who owns each channel, whether the write address is already sent, and the RR pointers.
  initial begin
    axi_mosi_t em;
    axi_miso_t es [N];
    int jb, jr, g;
    bit awhs, wlhs;
    wb = 0; wad = 0; rb = 0; wo = 0; wp = 0; ro = 0; rp = 0;
    forever begin
      @(negedge ACLK);
      cyc++;
      em = '0;
      for (int i = 0; i < N; i++) es[i] = '0;
      if (!ARESET) begin
        if (wb) begin
          if (!wad) begin
            em.awid    = s_axi_i[wo].awid;
            em.awaddr  = s_axi_i[wo].awaddr;
            em.awlen   = s_axi_i[wo].awlen;
            em.awsize  = s_axi_i[wo].awsize;
            em.awburst = s_axi_i[wo].awburst;
            em.awvalid = s_axi_i[wo].awvalid;
            es[wo].awready = m_axi_i.awready;
          end
          em.wdata  = s_axi_i[wo].wdata;
          em.wstrb  = s_axi_i[wo].wstrb;
          em.wlast  = s_axi_i[wo].wlast;
          em.wvalid = s_axi_i[wo].wvalid;
          es[wo].wready = m_axi_i.wready;
        end
        if (rb) begin
          em.arid    = s_axi_i[ro].arid;
          em.araddr  = s_axi_i[ro].araddr;
          em.arlen   = s_axi_i[ro].arlen;
          em.arsize  = s_axi_i[ro].arsize;
          em.arburst = s_axi_i[ro].arburst;
          em.arvalid = s_axi_i[ro].arvalid;
          es[ro].arready = m_axi_i.arready;
        end
        jb = route_of(int'(m_axi_i.bid));
        es[jb].bvalid = m_axi_i.bvalid;
        es[jb].bid    = m_axi_i.bid;
        es[jb].bresp  = m_axi_i.bresp;
        em.bready     = s_axi_i[jb].bready;
        jr = route_of(int'(m_axi_i.rid));
        es[jr].rvalid = m_axi_i.rvalid;
        es[jr].rid    = m_axi_i.rid;
        es[jr].rdata  = m_axi_i.rdata;
        es[jr].rresp  = m_axi_i.rresp;
        es[jr].rlast  = m_axi_i.rlast;
        em.rready     = s_axi_i[jr].rready;
      end
      chk("m_axi_o", 128'(m_axi_o), 128'(em));
      for (int i = 0; i < N; i++) chk($sformatf("s_axi_o[%0d]", i), 128'(s_axi_o[i]), 128'(es[i]));

      if (m_axi_o.awvalid && m_axi_i.awready) begin
        aw_src.push_back(int'(m_axi_o.awaddr[11:8])); aw_cyc.push_back(cyc);
      end
      if (m_axi_o.wvalid && m_axi_i.wready) begin
        w_src.push_back(int'(m_axi_o.wdata[31:28])); w_cyc.push_back(cyc);
      end
      if (m_axi_o.arvalid && m_axi_i.arready) begin
        ar_src.push_back(int'(m_axi_o.araddr[11:8])); ar_cyc.push_back(cyc);
      end

      if (ARESET) begin
        wb = 0; wad = 0; rb = 0; wo = 0; wp = 0; ro = 0; rp = 0;
      end else begin
        if (!wb) begin
          g = first_req(wp, 1'b1);
          if (g >= 0) begin wb = 1; wo = g; wad = 0; end
        end else begin
          awhs = !wad && s_axi_i[wo].awvalid && m_axi_i.awready;
          wlhs = s_axi_i[wo].wvalid && m_axi_i.wready && s_axi_i[wo].wlast;
          if ((wad || awhs) && wlhs) wb = 0;
          if (awhs) begin wad = 1; wp = (wo + 1) % N; end
        end
        if (!rb) begin
          g = first_req(rp, 1'b0);
          if (g >= 0) begin rb = 1; ro = g; end
        end else if (s_axi_i[ro].arvalid && m_axi_i.arready) begin
          rb = 0; rp = (ro + 1) % N;
        end
      end
    end
  end

  initial begin
    int rel, cnt, base, na;
    m_axi_i = '0;
    clear_up();
    for (int i = 0; i < N; i++) begin w_beat[i] = 0; bready_v[i] = 1; rready_v[i] = 1; end

    // Reset state, with inputs 0 and 2 already requesting 4-beat writes.
    aw_req[0] = 1; aw_len[0] = 3; w_left[0] = 4; w_en[0] = 1;
    aw_req[2] = 1; aw_len[2] = 3; w_left[2] = 4; w_en[2] = 1;
    tick(2);
    @(negedge ACLK);
    chk("rst_m_axi_o", 128'(m_axi_o), 128'(0));
    for (int i = 0; i < N; i++) chk($sformatf("rst_s_axi_o%0d", i), 128'(s_axi_o[i]), 128'(0));
    tick(1);
    m_axi_i.awready = 1; m_axi_i.wready = 1; m_axi_i.arready = 1;
    ARESET = 0;
    rel = cyc;
    for (int k = 0; k < 60 && w_src.size() < 8; k++) tick(1);
    chk("t1_wbeats", 128'(w_src.size()), 128'(8));
    chk("t1_first_aw", 128'(aw_src[0]), 128'(0));
    chk("t1_second_aw", 128'(aw_src[1]), 128'(2));
    chk("t1_aw_latency", 128'(aw_cyc[0] - rel), 128'(2));
    cnt = 0;
    for (int k = 0; k < 4; k++) if (w_src[k] == 0) cnt++;
    chk("t1_in0_beats", 128'(cnt), 128'(4));
    chk("t1_fifth_beat", 128'(w_src[4]), 128'(2));

    // Pointer back at 0: with 0 and 2 requesting, 0 wins.
    aw_req[0] = 1; aw_len[0] = 0; w_left[0] = 1;
    aw_req[2] = 1; aw_len[2] = 0; w_left[2] = 1;
    for (int k = 0; k < 30 && w_src.size() < 10; k++) tick(1);
    chk("t1_ptr_first", 128'(aw_src[2]), 128'(0));
    chk("t1_ptr_second", 128'(aw_src[3]), 128'(2));

    // W before AW on input 1: both handshakes in the address cycle.
    w_en[1] = 1; w_left[1] = 1;
    tick(2);
    aw_req[1] = 1; aw_len[1] = 0;
    aw_req[2] = 1; aw_len[2] = 0; w_left[2] = 1;
    for (int k = 0; k < 30 && w_src.size() < 12; k++) tick(1);
    chk("t2_aw_order1", 128'(aw_src[4]), 128'(1));
    chk("t2_aw_order2", 128'(aw_src[5]), 128'(2));
    chk("t2_w_src", 128'(w_src[10]), 128'(1));
    chk("t2_same_cycle", 128'(w_cyc[10]), 128'(aw_cyc[4]));
    chk("t2_aw_spacing", 128'(aw_cyc[5] - aw_cyc[4]), 128'(2));

    // R routing by RID and backpressure.
    tick(2);
    m_axi_i.rvalid = 1; m_axi_i.rid = 4'd1; m_axi_i.rdata = 32'hA1A1_0001; m_axi_i.rlast = 1;
    @(negedge ACLK);
    chk("t3_rid1_in1", 128'(s_axi_o[1].rvalid), 128'(1));
    chk("t3_rid1_data", 128'(s_axi_o[1].rdata), 128'(32'hA1A1_0001));
    chk("t3_rid1_in0", 128'(s_axi_o[0].rvalid), 128'(0));
    chk("t3_rid1_in2", 128'(s_axi_o[2].rvalid), 128'(0));
    tick(1);
    m_axi_i.rid = 4'd0;
    @(negedge ACLK);
    chk("t3_rid0_in0", 128'(s_axi_o[0].rvalid), 128'(1));
    chk("t3_rid0_in1", 128'(s_axi_o[1].rvalid), 128'(0));
    tick(1);
    m_axi_i.rid = 4'd7;
    @(negedge ACLK);
    chk("t3_rid7_in2", 128'(s_axi_o[2].rvalid), 128'(1));
    chk("t3_rid7_rready", 128'(m_axi_o.rready), 128'(1));
    tick(1);
    rready_v[2] = 0;
    @(negedge ACLK);
    chk("t3_bp_rready", 128'(m_axi_o.rready), 128'(0));
    chk("t3_bp_rvalid", 128'(s_axi_o[2].rvalid), 128'(1));
    tick(1);
    rready_v[2] = 1; m_axi_i.rvalid = 0; m_axi_i.rid = 0; m_axi_i.rlast = 0;

    // Continuous AR from all inputs.
    for (int i = 0; i < N; i++) ar_left[i] = 2;
    for (int k = 0; k < 40 && ar_src.size() < 6; k++) tick(1);
    chk("t4_ar_count", 128'(ar_src.size()), 128'(6));
    for (int k = 0; k < 6; k++) chk($sformatf("t4_ar_order%0d", k), 128'(ar_src[k]), 128'(k % 3));
    for (int k = 1; k < 6; k++)
      chk($sformatf("t4_ar_gap%0d", k), 128'(ar_cyc[k] - ar_cyc[k-1]), 128'(2));

    // Reset during beat 2 of a 4-beat write.
    tick(2);
    base = w_src.size();
    aw_req[0] = 1; aw_len[0] = 3; w_left[0] = 4; w_en[0] = 1;
    for (int k = 0; k < 20 && w_src.size() < base + 1; k++) tick(1);
    ARESET = 1;
    clear_up();
    @(negedge ACLK);
    chk("t5_m_idle", 128'(m_axi_o), 128'(0));
    chk("t5_s0_idle", 128'(s_axi_o[0]), 128'(0));
    tick(1);
    ARESET = 0;
    na = aw_src.size();
    aw_req[1] = 1; aw_len[1] = 0; w_left[1] = 1; w_en[1] = 1;
    for (int k = 0; k < 20 && w_src.size() < base + 2; k++) tick(1);
    chk("t5_next_aw", 128'(aw_src[na]), 128'(1));
    chk("t5_beat1", 128'(w_src[base]), 128'(0));
    chk("t5_next_w", 128'(w_src[base+1]), 128'(1));

    // B routing with target backpressure.
    tick(2);
    bready_v[0] = 0;
    m_axi_i.bvalid = 1; m_axi_i.bid = 4'd0; m_axi_i.bresp = 2'd0;
    @(negedge ACLK);
    chk("t6_bready_low", 128'(m_axi_o.bready), 128'(0));
    chk("t6_b_in0", 128'(s_axi_o[0].bvalid), 128'(1));
    chk("t6_b_in1", 128'(s_axi_o[1].bvalid), 128'(0));
    chk("t6_b_in2", 128'(s_axi_o[2].bvalid), 128'(0));
    tick(1);
    bready_v[0] = 1;
    @(negedge ACLK);
    chk("t6_bready_high", 128'(m_axi_o.bready), 128'(1));
    chk("t6_b_in1_still", 128'(s_axi_o[1].bvalid), 128'(0));
    tick(1);
    m_axi_i.bid = 4'd9;
    @(negedge ACLK);
    chk("t6_bid9_in2", 128'(s_axi_o[2].bvalid), 128'(1));
    chk("t6_bid9_in0", 128'(s_axi_o[0].bvalid), 128'(0));
    tick(1);
    m_axi_i.bvalid = 0; m_axi_i.bid = 0;
    tick(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
